// File: rtl/oci_trace_pkg.sv
// Shared types and helpers for the OCI data-capture-trace recorder.
// Imported by the capture top level and its FIFO.
package oci_trace_pkg;

    typedef enum logic [1:0] {
        CAPTURE,
        DRAIN,
        DONE
    } trace_state_e;

    // Widest drop counter supported; the top level slices this down to DROP_W.
    localparam int unsigned DROP_W_MAX = 64;
    localparam logic [DROP_W_MAX-1:0] DROP_SAT_FULL = '1;

    function automatic int entry_w(input int dct_w, input int cnt_w);
        return dct_w + cnt_w;
    endfunction

endpackage

// File: rtl/oci_trace_capture_if.sv
// Trace input and FWFT read port of the trace recorder.
// The producer and consumer side is master; the recorder is slave.
interface oci_trace_capture_if #(
    parameter int DCT_W = 30,
    parameter int CNT_W = 4
);
    logic                     dct_valid;
    logic [DCT_W-1:0]         dct_buffer;
    logic [CNT_W-1:0]         dct_count;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [CNT_W+DCT_W-1:0]   rd_data;

    modport master (
        output dct_valid, dct_buffer, dct_count, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/oci_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with an exact occupancy count.
// The head entry is read from storage through the registered read pointer.
module oci_trace_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/oci_trace_capture.sv
// Captures core data-capture-trace words into a bounded FIFO, counts overflow
// drops and runs the end-of-test drain sequence.
module oci_trace_capture
    import oci_trace_pkg::*;
#(
    parameter int DCT_W  = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    oci_trace_capture_if.slave      trace,
    input  logic                    test_ending,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count,
    output logic                    draining,
    output logic                    test_has_ended
);
    localparam int ENTRY_W = entry_w(DCT_W, CNT_W);
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam logic [DROP_W-1:0] DROP_SAT = DROP_SAT_FULL[DROP_W-1:0];

    trace_state_e       state;
    logic               word_ok;
    logic               push;
    logic               pop;
    logic               drop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Zero-count words carry no trace fields and are discarded without counting as drops.
    always_comb begin
        word_ok = trace.dct_valid && (trace.dct_count != '0) && (state == CAPTURE);
        pop     = trace.rd_ready && !fifo_empty;
        push    = word_ok && (!fifo_full || pop);
        drop    = word_ok && fifo_full && !pop;
    end

    assign trace.rd_valid = !fifo_empty;
    assign trace.rd_data  = fifo_rdata;

    oci_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({trace.dct_count, trace.dct_buffer}),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fill_level)
    );

    // DRAIN ends on the edge that empties the FIFO, or on its first edge if already empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= CAPTURE;
            draining       <= 1'b0;
            test_has_ended <= 1'b0;
            overflow       <= 1'b0;
            drop_count     <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_SAT) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
            case (state)
                CAPTURE: begin
                    if (test_ending) begin
                        state    <= DRAIN;
                        draining <= 1'b1;
                    end
                end
                DRAIN: begin
                    if ((fill_level == '0) || ((fill_level == LVL_W'(1)) && pop)) begin
                        state          <= DONE;
                        draining       <= 1'b0;
                        test_has_ended <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
